// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
//   Constants shared by the operand-issue stage, its register file and the
//   downstream ALU: 4-bit opcode encodings, instruction field positions and
//   the default datapath / register-file dimensions.
//   Configuration macro used by the issue stage: ALU_ISSUE_FWD_EN.
// ---------------------------------------------------------------------------
package alu_pkg;

   localparam int unsigned ALU_XLEN  = 32;
   localparam int unsigned ALU_NREGS = 32;

   // opcode encodings
   localparam logic [3:0] OP_NOOP = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_MUL  = 4'd3;
   localparam logic [3:0] OP_DIV  = 4'd4;
   localparam logic [3:0] OP_SLL  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_SLTU = 4'd7;
   localparam logic [3:0] OP_AND  = 4'd8;
   localparam logic [3:0] OP_OR   = 4'd9;
   localparam logic [3:0] OP_SRL  = 4'd10;
   localparam logic [3:0] OP_SRA  = 4'd11;
   localparam logic [3:0] OP_XOR  = 4'd12;

   // instruction word field positions
   localparam int unsigned F_OP_MSB  = 31;
   localparam int unsigned F_OP_LSB  = 28;
   localparam int unsigned F_RD_MSB  = 27;
   localparam int unsigned F_RD_LSB  = 23;
   localparam int unsigned F_RS_MSB  = 22;
   localparam int unsigned F_RS_LSB  = 18;
   localparam int unsigned F_RT_MSB  = 17;
   localparam int unsigned F_RT_LSB  = 13;
   localparam int unsigned F_USE_IMM = 12;
   localparam int unsigned F_IMM_MSB = 11;
   localparam int unsigned F_IMM_LSB = 0;
   localparam int unsigned IMM_W     = F_IMM_MSB - F_IMM_LSB + 1;

endpackage

// File: rtl/alu_regfile.sv
// ---------------------------------------------------------------------------
// alu_regfile
//   NREGS x XLEN register file, two combinational read ports, one write port.
//   Register 0 always reads zero and ignores writes. Asynchronous active-low
//   clear of every entry.
//   With ALU_ISSUE_FWD_EN defined, a read of the register being written this
//   cycle returns the write data (writeback bypass).
//
//   clk, rst_n              clock, async active-low clear
//   rd_addr_a / rd_data_a   read port A
//   rd_addr_b / rd_data_b   read port B
//   wr_en, wr_addr, wr_data write port
// ---------------------------------------------------------------------------
module alu_regfile
   import alu_pkg::*;
#(
   parameter int unsigned NREGS = ALU_NREGS,
   parameter int unsigned XLEN  = ALU_XLEN,
   parameter int unsigned AW    = $clog2(NREGS)
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [AW-1:0]   rd_addr_a,
   output logic [XLEN-1:0] rd_data_a,
   input  logic [AW-1:0]   rd_addr_b,
   output logic [XLEN-1:0] rd_data_b,
   input  logic            wr_en,
   input  logic [AW-1:0]   wr_addr,
   input  logic [XLEN-1:0] wr_data
);

   logic [XLEN-1:0] regs [NREGS];
   logic            wr_hit;

   assign wr_hit = wr_en && (wr_addr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int unsigned i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else if (wr_hit) begin
         regs[wr_addr] <= wr_data;
      end
   end

   always_comb begin
      rd_data_a = '0;
      rd_data_b = '0;
      if (rd_addr_a != '0) begin
         rd_data_a = regs[rd_addr_a];
`ifdef ALU_ISSUE_FWD_EN
         if (wr_hit && (wr_addr == rd_addr_a)) begin
            rd_data_a = wr_data;
         end
`endif
      end
      if (rd_addr_b != '0) begin
         rd_data_b = regs[rd_addr_b];
`ifdef ALU_ISSUE_FWD_EN
         if (wr_hit && (wr_addr == rd_addr_b)) begin
            rd_data_b = wr_data;
         end
`endif
      end
   end

endmodule

// File: rtl/alu_issue_stage.sv
// ---------------------------------------------------------------------------
// alu_issue_stage
//   Operand-issue stage upstream of the ALU. Decodes instruction words,
//   reads operands from alu_regfile, tracks RAW/WAW hazards with a
//   per-register busy scoreboard and presents the issued instruction in a
//   registered valid/ready output slot. The writeback port writes the
//   register file and clears busy bits.
//   Configuration macro: ALU_ISSUE_FWD_EN (writeback bypass; a writeback this
//   cycle masks the matching busy bit and supplies the operand value).
//
//   clk, rst_n                      clock, async active-low reset
//   in_valid, in_ready, in_instr    instruction input handshake
//   out_valid, out_ready            operand slot handshake
//   out_op, out_a, out_b, out_rd,   issued opcode, operands, destination,
//   out_dz                          divide-by-zero flag
//   wb_en, wb_addr, wb_data         writeback port
// ---------------------------------------------------------------------------
module alu_issue_stage
   import alu_pkg::*;
#(
   parameter int unsigned NREGS = ALU_NREGS,
   parameter int unsigned XLEN  = ALU_XLEN
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_op,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [4:0]      out_rd,
   output logic            out_dz,
   input  logic            wb_en,
   input  logic [4:0]      wb_addr,
   input  logic [XLEN-1:0] wb_data
);

   // decode
   logic [3:0]       dec_op;
   logic [4:0]       dec_rd;
   logic [4:0]       dec_rs;
   logic [4:0]       dec_rt;
   logic             dec_use_imm;
   logic [IMM_W-1:0] dec_imm;
   logic [XLEN-1:0]  imm_sext;

   assign dec_op      = in_instr[F_OP_MSB:F_OP_LSB];
   assign dec_rd      = in_instr[F_RD_MSB:F_RD_LSB];
   assign dec_rs      = in_instr[F_RS_MSB:F_RS_LSB];
   assign dec_rt      = in_instr[F_RT_MSB:F_RT_LSB];
   assign dec_use_imm = in_instr[F_USE_IMM];
   assign dec_imm     = in_instr[F_IMM_MSB:F_IMM_LSB];
   assign imm_sext    = {{(XLEN-IMM_W){dec_imm[IMM_W-1]}}, dec_imm};

   // operand read
   logic [XLEN-1:0] rs_val;
   logic [XLEN-1:0] rt_val;

   alu_regfile #(
      .NREGS (NREGS),
      .XLEN  (XLEN),
      .AW    (5)
   ) u_regfile (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr_a (dec_rs),
      .rd_data_a (rs_val),
      .rd_addr_b (dec_rt),
      .rd_data_b (rt_val),
      .wr_en     (wb_en),
      .wr_addr   (wb_addr),
      .wr_data   (wb_data)
   );

   logic [XLEN-1:0] b_val;
   logic [4:0]      rd_eff;
   logic            dz_val;

   assign b_val  = dec_use_imm ? imm_sext : rt_val;
   assign rd_eff = (dec_op == OP_NOOP) ? 5'd0 : dec_rd;
   assign dz_val = (dec_op == OP_DIV) && (b_val == '0);

   // scoreboard
   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_d;
   logic [NREGS-1:0] busy_eff;
   logic [NREGS-1:0] wb_clr;
   logic [NREGS-1:0] iss_set;
   logic             hazard;
   logic             slot_free;
   logic             accept;

   always_comb begin
      wb_clr = '0;
      if (wb_en && (wb_addr != 5'd0)) begin
         wb_clr[wb_addr] = 1'b1;
      end
   end

`ifdef ALU_ISSUE_FWD_EN
   assign busy_eff = busy_q & ~wb_clr;
`else
   assign busy_eff = busy_q;
`endif

   // busy[0] is never set, so r0 sources/destinations never stall
   assign hazard = busy_eff[dec_rs]
                 | (~dec_use_imm & busy_eff[dec_rt])
                 | ((dec_rd != 5'd0) & busy_eff[dec_rd]);

   assign slot_free = ~out_valid | out_ready;
   assign in_ready  = slot_free & ~hazard;
   assign accept    = in_valid & in_ready;

   always_comb begin
      iss_set = '0;
      if (accept && (rd_eff != 5'd0)) begin
         iss_set[rd_eff] = 1'b1;
      end
   end

   // clear first, then set, so a same-cycle set wins
   always_comb begin
      busy_d    = (busy_q & ~wb_clr) | iss_set;
      busy_d[0] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_d;
      end
   end

   // output slot
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_op    <= '0;
         out_a     <= '0;
         out_b     <= '0;
         out_rd    <= '0;
         out_dz    <= 1'b0;
      end else if (accept) begin
         out_valid <= 1'b1;
         out_op    <= dec_op;
         out_a     <= rs_val;
         out_b     <= b_val;
         out_rd    <= rd_eff;
         out_dz    <= dz_val;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_issue_stage.sv
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_op;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [4:0]  out_rd;
   logic        out_dz;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;

   alu_issue_stage #(
      .NREGS (32),
      .XLEN  (32)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_instr  (in_instr),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_op    (out_op),
      .out_a     (out_a),
      .out_b     (out_b),
      .out_rd    (out_rd),
      .out_dz    (out_dz),
      .wb_en     (wb_en),
      .wb_addr   (wb_addr),
      .wb_data   (wb_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [4:0]  rd;
      logic        dz;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] mregs [32];
   int          vectors = 0;
   int          miscompares = 0;

   function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                      input logic [4:0] rs, input logic [4:0] rt,
                                      input logic use_imm, input logic [11:0] imm);
      return {op, rd, rs, rt, use_imm, imm};
   endfunction

   function automatic exp_t model(input logic [31:0] ins);
      exp_t e;
      logic [11:0] imm;
      imm  = ins[11:0];
      e.op = ins[31:28];
      e.rd = (e.op == 4'd0) ? 5'd0 : ins[27:23];
      e.a  = (ins[22:18] == 5'd0) ? 32'd0 : mregs[ins[22:18]];
      if (ins[12]) e.b = {{20{imm[11]}}, imm};
      else         e.b = (ins[17:13] == 5'd0) ? 32'd0 : mregs[ins[17:13]];
      e.dz = (e.op == 4'd4) && (e.b == 32'd0);
      return e;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, expv);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      if (exp_q.size() == 0) begin
         chk({tag, "_queue_empty"}, 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
         chk({tag, "_op"},    {28'd0, out_op}, {28'd0, e.op});
         chk({tag, "_a"},     out_a, e.a);
         chk({tag, "_b"},     out_b, e.b);
         chk({tag, "_rd"},    {27'd0, out_rd}, {27'd0, e.rd});
         chk({tag, "_dz"},    {31'd0, out_dz}, {31'd0, e.dz});
      end
   endtask

   // present an instruction, wait (bounded) for acceptance, then check the slot
   task automatic issue(input string tag, input logic [31:0] ins, output int waited);
      waited   = 0;
      in_instr = ins;
      in_valid = 1'b1;
      #1;
      while (!in_ready && waited < 20) begin
         tick();
         waited++;
      end
      if (!in_ready) begin
         chk({tag, "_accept_timeout"}, 32'd0, 32'd1);
         in_valid = 1'b0;
      end else begin
         exp_q.push_back(model(ins));
         @(posedge clk);
         #1;
         in_valid = 1'b0;
         pop_check(tag);
      end
   endtask

   task automatic writeback(input logic [4:0] addr, input logic [31:0] data);
      wb_en   = 1'b1;
      wb_addr = addr;
      wb_data = data;
      tick();
      wb_en = 1'b0;
      if (addr != 5'd0) mregs[addr] = data;
   endtask

   initial begin
      int          w;
      exp_t        snap;
      logic [31:0] ins2;

      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_instr  = 32'd0;
      out_ready = 1'b1;
      wb_en     = 1'b0;
      wb_addr   = 5'd0;
      wb_data   = 32'd0;
      tick();
      tick();
      rst_n = 1'b1;
      #1;

      // reset state
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_op",    {28'd0, out_op}, 32'd0);
      chk("rst_out_a",     out_a, 32'd0);
      chk("rst_out_b",     out_b, 32'd0);
      chk("rst_out_rd",    {27'd0, out_rd}, 32'd0);
      chk("rst_out_dz",    {31'd0, out_dz}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
      tick();

      // ADD rd3 = r0 + sext(0xFFF)
      issue("add_imm", mk(4'd1, 5'd3, 5'd0, 5'd0, 1'b1, 12'hFFF), w);
      chk("add_imm_b_abs", out_b, 32'hFFFF_FFFF);

      // SUB rd4 = r3 - 1 while r3 busy
      in_instr = mk(4'd2, 5'd4, 5'd3, 5'd0, 1'b1, 12'd1);
      in_valid = 1'b1;
      #1;
      chk("raw_stall_0", {31'd0, in_ready}, 32'd0);
      tick();
      chk("raw_stall_1", {31'd0, in_ready}, 32'd0);
      wb_en   = 1'b1;
      wb_addr = 5'd3;
      wb_data = 32'd7;
`ifdef ALU_ISSUE_FWD_EN
      mregs[3] = 32'd7;
      #1;
      chk("raw_fwd_ready", {31'd0, in_ready}, 32'd1);
      exp_q.push_back(model(in_instr));
      tick();
      wb_en    = 1'b0;
      in_valid = 1'b0;
`else
      #1;
      chk("raw_wb_cycle_stall", {31'd0, in_ready}, 32'd0);
      tick();
      wb_en    = 1'b0;
      mregs[3] = 32'd7;
      #1;
      chk("raw_after_wb_ready", {31'd0, in_ready}, 32'd1);
      exp_q.push_back(model(in_instr));
      tick();
      in_valid = 1'b0;
`endif
      pop_check("raw_issue");
      chk("raw_issue_a_abs", out_a, 32'd7);
      writeback(5'd4, 32'd100);

      // backpressure: hold slot for 5 cycles then back-to-back replacement
      out_ready = 1'b0;
      issue("bp_first", mk(4'd1, 5'd5, 5'd3, 5'd0, 1'b0, 12'd0), w);
      snap = model(mk(4'd1, 5'd5, 5'd3, 5'd0, 1'b0, 12'd0));
      ins2 = mk(4'd9, 5'd7, 5'd4, 5'd0, 1'b1, 12'd5);
      in_instr = ins2;
      in_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
         chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
         chk("bp_hold_a", out_a, snap.a);
         chk("bp_hold_rd", {27'd0, out_rd}, {27'd0, snap.rd});
         chk("bp_hold_op", {28'd0, out_op}, {28'd0, snap.op});
         tick();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
      exp_q.push_back(model(ins2));
      tick();
      in_valid = 1'b0;
      pop_check("bp_replace");
      tick();
      writeback(5'd5, 32'd0);
      writeback(5'd7, 32'd0);

      // DIV with zero / non-zero divisor
      writeback(5'd1, 32'd20);
      writeback(5'd2, 32'd0);
      issue("div_zero", mk(4'd4, 5'd5, 5'd1, 5'd2, 1'b0, 12'd0), w);
      chk("div_zero_dz_abs", {31'd0, out_dz}, 32'd1);
      writeback(5'd5, 32'd0);
      writeback(5'd2, 32'd3);
      issue("div_nz", mk(4'd4, 5'd5, 5'd1, 5'd2, 1'b0, 12'd0), w);
      chk("div_nz_dz_abs", {31'd0, out_dz}, 32'd0);
      writeback(5'd5, 32'd0);

      // write to r0 ignored
      writeback(5'd0, 32'h55);
      issue("r0_read", mk(4'd1, 5'd8, 5'd0, 5'd0, 1'b0, 12'd0), w);
      chk("r0_read_a_abs", out_a, 32'd0);
      writeback(5'd8, 32'd0);

      // NOOP with rd=9: rd forced to 0, r9 not marked busy
      issue("noop", mk(4'd0, 5'd9, 5'd1, 5'd0, 1'b1, 12'd4), w);
      in_instr = mk(4'd2, 5'd10, 5'd9, 5'd0, 1'b1, 12'd0);
      in_valid = 1'b1;
      #1;
      chk("noop_no_busy", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      tick();

      // opcode 13 passes through; negative immediate on B
      issue("op13", mk(4'd13, 5'd11, 5'd1, 5'd0, 1'b1, 12'h800), w);
      writeback(5'd11, 32'd0);

      // full throughput: four independent instructions, no stalls
      for (int k = 0; k < 4; k++) begin
         issue("thru", mk(4'd12, 5'(12 + k), 5'd1, 5'd2, 1'b0, 12'd0), w);
         chk("thru_no_wait", w, 32'd0);
      end
      tick();
      for (int k = 0; k < 4; k++) writeback(5'(12 + k), 32'd0);

      // asynchronous reset mid-operation
      out_ready = 1'b0;
      issue("pre_rst", mk(4'd1, 5'd6, 5'd1, 5'd0, 1'b1, 12'd1), w);
      in_instr = mk(4'd1, 5'd9, 5'd6, 5'd0, 1'b1, 12'd0);
      in_valid = 1'b1;
      #1;
      chk("pre_rst_blocked", {31'd0, in_ready}, 32'd0);
      out_ready = 1'b1;
      #1;
      chk("pre_rst_hazard", {31'd0, in_ready}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("arst_valid", {31'd0, out_valid}, 32'd0);
      chk("arst_op", {28'd0, out_op}, 32'd0);
      chk("arst_rd", {27'd0, out_rd}, 32'd0);
      chk("arst_busy_clear", {31'd0, in_ready}, 32'd1);
      in_valid = 1'b0;
      tick();
      rst_n = 1'b1;
      exp_q.delete();
      for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
      #1;
      issue("post_rst_r1", mk(4'd1, 5'd6, 5'd1, 5'd0, 1'b0, 12'd0), w);
      chk("post_rst_r1_a_abs", out_a, 32'd0);
      chk("post_rst_no_wait", w, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
